// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war computer opponent.
package tug_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS    = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  localparam int LFSR_TAP_A = 9;
  localparam int LFSR_TAP_B = 6;

endpackage

// File: rtl/lfsr10.sv
// 10-bit XNOR Fibonacci LFSR; all-zeros is a valid state, all-ones is lock-up.
module lfsr10
  import tug_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // NOTE: sequential state uses non-blocking assignment; reset is synchronous here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (adv) begin
      r_q <= {r_q[WIDTH-2:0], ~(r_q[LFSR_TAP_A] ^ r_q[LFSR_TAP_B])};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/computer_player.sv
// Automated tug-of-war opponent: a rate divider and LFSR decide when to emit
// one-cycle press pulses, with at least one decision tick of release between.
module computer_player
  import tug_pkg::*;
#(
  parameter int LFSR_WIDTH = 10,
  parameter int TICK_BITS  = 22
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  game_over,
  input  logic [LFSR_WIDTH-1:0] threshold,
  output logic                  press,
  output logic [LFSR_WIDTH-1:0] lfsr_q
);

  logic                 w_run;
  logic                 w_tick;
  logic [TICK_BITS-1:0] r_tick_cnt;
  state_t               r_state;
  state_t               w_state_next;
  logic                 r_press;

  assign w_run  = enable & ~game_over;
  assign w_tick = w_run & (&r_tick_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (w_run) begin
      r_tick_cnt <= r_tick_cnt + TICK_BITS'(1);
    end
  end

  lfsr10 #(
    .WIDTH(LFSR_WIDTH)
  ) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .adv  (w_tick),
    .q    (lfsr_q)
  );

  // The press decision compares the LFSR value from before this tick's advance.
  always_comb begin
    // NOTE: default first so every path assigns w_state_next and no latch is inferred.
    w_state_next = r_state;
    if (!w_run) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:     if (w_tick && (lfsr_q < threshold)) w_state_next = PRESS;
        PRESS:    w_state_next = COOLDOWN;
        COOLDOWN: if (w_tick) w_state_next = IDLE;
        default:  w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_press <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_press <= (w_state_next == PRESS);
    end
  end

  assign press = r_press;

endmodule

// File: tb/tb_computer_player.sv
// Directed self-checking bench for computer_player with a 4-cycle decision tick.
module tb_computer_player;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         game_over;
  logic [W-1:0] threshold;
  logic         press;
  logic [W-1:0] lfsr_q;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_consec = 0;
  logic prev_press = 1'b0;

  computer_player #(
    .LFSR_WIDTH(W),
    .TICK_BITS (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .game_over(game_over),
    .threshold(threshold),
    .press    (press),
    .lfsr_q   (lfsr_q)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (press === 1'b1 && prev_press === 1'b1) n_consec++;
    prev_press = press;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) step();
  endtask

  // After this returns, the bench sits in enabled cycle 1 (tick_cnt = 0).
  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    cyc   = 1;
  endtask

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] v);
    return {v[8:0], ~(v[9] ^ v[6])};
  endfunction

  logic [W-1:0] exp_seq [9] = '{10'h001, 10'h003, 10'h007, 10'h00F, 10'h01F,
                                10'h03F, 10'h07F, 10'h0FE, 10'h1FC};

  initial begin
    int hits;
    int mism;
    int seen_3ff;
    int early_zero;
    logic [W-1:0] m;

    reset     = 1'b1;
    enable    = 1'b1;
    game_over = 1'b0;
    threshold = '0;

    // Reset, first tick on enabled cycle 4, threshold 0 never presses.
    do_reset();
    check("reset_press", press, 0);
    check("reset_lfsr", lfsr_q, 0);
    hits = 0;
    while (cyc <= 400) begin
      if (press) hits++;
      if (cyc == 4) check("pre_first_tick_lfsr", lfsr_q, 0);
      if (cyc >= 5 && ((cyc - 5) % 4) == 0 && ((cyc - 5) / 4) < 9)
        check($sformatf("lfsr_seq%0d", (cyc - 5) / 4), lfsr_q, exp_seq[(cyc - 5) / 4]);
      step();
    end
    check("thr0_press_count", hits, 0);

    // threshold all-ones: press at cycle 5 and every 8 cycles after.
    threshold = 10'h3FF;
    do_reset();
    while (cyc <= 40) begin
      check($sformatf("thr_max_press_c%0d", cyc), press,
            (cyc >= 5 && ((cyc - 5) % 8) == 0) ? 1 : 0);
      step();
    end

    // Full LFSR period: back to 000 after exactly 1023 advances, never 3FF.
    do_reset();
    m = '0; mism = 0; seen_3ff = 0; early_zero = 0;
    while (cyc <= 4093) begin
      if (cyc >= 5 && ((cyc - 5) % 4) == 0) m = lfsr_step(m);
      if (lfsr_q !== m) mism++;
      if (lfsr_q == 10'h3FF) seen_3ff++;
      if (cyc >= 5 && cyc < 4093 && lfsr_q == 10'h000) early_zero++;
      if (cyc == 4093) check("period_return_zero", lfsr_q, 0);
      if (cyc < 4093) step(); else break;
    end
    check("period_model_mismatch", mism, 0);
    check("period_seen_3ff", seen_3ff, 0);
    check("period_early_zero", early_zero, 0);

    // game_over during COOLDOWN freezes everything; resumes from IDLE.
    do_reset();
    go_to(6);
    game_over = 1'b1;
    hits = 0; mism = 0;
    repeat (20) begin
      if (press) hits++;
      if (lfsr_q !== 10'h001) mism++;
      step();
    end
    check("go_press_count", hits, 0);
    check("go_lfsr_frozen_errs", mism, 0);
    game_over = 1'b0;
    check("go_resume_c26", press, 0);
    go_to(28);
    check("go_resume_c28", press, 0);
    go_to(29);
    check("go_resume_press", press, 1);
    check("go_resume_lfsr", lfsr_q, 10'h003);

    // Reset in the press cycle clears everything on the next edge.
    reset = 1'b1;
    step();
    check("midreset_press", press, 0);
    check("midreset_lfsr", lfsr_q, 0);
    step();
    reset = 1'b0;
    cyc = 1;
    go_to(4);
    check("midreset_c4_lfsr", lfsr_q, 0);
    check("midreset_c4_press", press, 0);
    go_to(5);
    check("midreset_c5_lfsr", lfsr_q, 10'h001);
    check("midreset_c5_press", press, 1);

    // Strict less-than compare and mid-run threshold changes.
    threshold = 10'h001;
    do_reset();
    go_to(5);
    check("thr1_press_c5", press, 1);
    go_to(10);
    threshold = 10'h003;
    go_to(13);
    check("thr3_no_press_c13", press, 0);
    check("thr3_lfsr_c13", lfsr_q, 10'h007);
    go_to(14);
    threshold = 10'h008;
    go_to(17);
    check("thr8_press_c17", press, 1);

    check("press_consecutive", n_consec, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
